// File: rtl/vga_timing_core.sv
// VGA timing generator: h/v counters, sync/DE pipeline aligned to a pixel generator, blanking and PMOD packing.
// Optional colour-bar test pattern is compiled in when VGA_TESTPAT_EN is defined.
module vga_timing_core #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int COLOR_BITS = 2,
  parameter int LATENCY    = 0,
  parameter int FRAME_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3*COLOR_BITS-1:0]   rgb_in,
`ifdef VGA_TESTPAT_EN
  input  logic                      testpat,
`endif
  output logic [9:0]                pix_x,
  output logic [9:0]                pix_y,
  output logic                      frame_start,
  output logic [FRAME_W-1:0]        frame_cnt,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic [3*COLOR_BITS-1:0]   rgb_out,
  output logic [7:0]                pmod_out
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int C        = COLOR_BITS;
  localparam int CW       = 3 * COLOR_BITS;
  localparam logic [9:0]         H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]         V_LAST = 10'(V_TOTAL - 1);
  localparam logic [FRAME_W-1:0] F_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};
`ifdef VGA_TESTPAT_EN
  localparam int PW = 6;
`else
  localparam int PW = 3;
`endif

  logic [9:0]         h_q, h_d, v_q, v_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic [31:0]        hx, vy;
  logic [PW-1:0]      stg_p0, stg_dly;
  logic [CW-1:0]      rgb_sel;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [CW-1:0]      rgb_q, rgb_d;

  always_comb begin
    h_d    = h_q + 10'd1;
    v_d    = v_q;
    fcnt_d = fcnt_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d    = '0;
        fcnt_d = fcnt_q + F_ONE;
      end else begin
        v_d = v_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      fcnt_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Stage 0: active-high flags {bar, vs, hs, de} decoded from the live counters
  assign hx = 32'(h_q);
  assign vy = 32'(v_q);
  always_comb begin
    stg_p0    = '0;
    stg_p0[0] = (hx < H_ACTIVE) && (vy < V_ACTIVE);
    stg_p0[1] = (hx >= HS_START) && (hx < HS_END);
    stg_p0[2] = (vy >= VS_START) && (vy < VS_END);
`ifdef VGA_TESTPAT_EN
    stg_p0[5:3] = h_q[9:7];
`endif
  end

  // Delay line: flags reset to zero, i.e. blank with syncs inactive
  generate
    if (LATENCY == 0) begin : g_nodly
      assign stg_dly = stg_p0;
    end else begin : g_dly
      logic [PW-1:0] pipe_q [LATENCY];
      logic [PW-1:0] pipe_d [LATENCY];
      always_comb begin
        pipe_d[0] = stg_p0;
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
        end
      end
      assign stg_dly = pipe_q[LATENCY-1];
    end
  endgenerate

  // Output stage: polarity applied and colour blanked in the same register as the syncs
  always_comb begin
    rgb_sel = rgb_in;
`ifdef VGA_TESTPAT_EN
    if (testpat) rgb_sel = {{C{stg_dly[3]}}, {C{stg_dly[4]}}, {C{stg_dly[5]}}};
`endif
    de_d    = stg_dly[0];
    hsync_d = stg_dly[1] ? H_POL : ~H_POL;
    vsync_d = stg_dly[2] ? V_POL : ~V_POL;
    rgb_d   = de_d ? rgb_sel : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign frame_start = (h_q == '0) && (v_q == '0);
  assign frame_cnt   = fcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb_out     = rgb_q;
  // TinyVGA PMOD keeps only the two MSBs of each channel
  assign pmod_out    = {hsync_q, rgb_q[C-2], rgb_q[2*C-2], rgb_q[3*C-2],
                        vsync_q, rgb_q[C-1], rgb_q[2*C-1], rgb_q[3*C-1]};

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: default 640x480 instance plus a tiny-timing instance (LATENCY=3, 3-bit colour, V_POL=1).
module tb_vga_timing_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [5:0] rgb_a, ro_a;
  logic [9:0] px_a, py_a;
  logic       fs_a, hs_a, vs_a, de_a;
  logic [7:0] fc_a, pm_a;
  logic [8:0] rgb_b, ro_b;
  logic [9:0] px_b, py_b;
  logic       fs_b, hs_b, vs_b, de_b;
  logic [7:0] fc_b, pm_b;
`ifdef VGA_TESTPAT_EN
  logic       testpat = 1'b0;
`endif

  vga_timing_core u_a (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_a),
`ifdef VGA_TESTPAT_EN
    .testpat(testpat),
`endif
    .pix_x(px_a), .pix_y(py_a), .frame_start(fs_a), .frame_cnt(fc_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb_out(ro_a), .pmod_out(pm_a)
  );

  vga_timing_core #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b1), .COLOR_BITS(3), .LATENCY(3), .FRAME_W(8)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_b),
`ifdef VGA_TESTPAT_EN
    .testpat(testpat),
`endif
    .pix_x(px_b), .pix_y(py_b), .frame_start(fs_b), .frame_cnt(fc_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb_out(ro_b), .pmod_out(pm_b)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic [7:0]  fc;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic [7:0]  pmod;
  } obs_t;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat, cb;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int         k;
    logic [5:0] rgb;
    logic [9:0] x;
    logic       hs;
    logic       de;
    logic [5:0] ro;
  } vec_t;

  obs_t  obs_a, obs_b;
  assign obs_a = {px_a, py_a, fs_a, fc_a, hs_a, vs_a, de_a, {6'b0, ro_a}, pm_a};
  assign obs_b = {px_b, py_b, fs_b, fc_b, hs_b, vs_b, de_b, {3'b0, ro_b}, pm_b};

  cfg_t   cfg_a, cfg_b;
  vec_t   tbl [10];
  longint k;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  // Reference: position after k edges is k mod frame; registered outputs describe position k-1-LATENCY.
  function automatic obs_t ref_model(input cfg_t c, input longint kk, input logic [11:0] rgb_prev);
    obs_t r;
    longint fr, n, m;
    int ht, vt, mx, my;
    logic dv, ha, va;
    logic [11:0] col;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    fr = longint'(ht) * vt;
    n  = kk % fr;
    r.x  = 10'(n % ht);
    r.y  = 10'(n / ht);
    r.fs = (n == 0);
    r.fc = 8'((kk / fr) % 256);
    m  = kk - 1 - c.lat;
    dv = 1'b0; ha = 1'b0; va = 1'b0;
    if (m >= 0) begin
      mx = int'((m % fr) % ht);
      my = int'((m % fr) / ht);
      dv = (mx < c.ha) && (my < c.va);
      ha = (mx >= c.ha + c.hfp) && (mx < c.ha + c.hfp + c.hsw);
      va = (my >= c.va + c.vfp) && (my < c.va + c.vfp + c.vsw);
    end
    r.hs = ha ? c.hpol : ~c.hpol;
    r.vs = va ? c.vpol : ~c.vpol;
    r.de = dv;
    col = '0;
    if (dv) for (int i = 0; i < 3 * c.cb; i++) col[i] = rgb_prev[i];
    r.rgb  = col;
    r.pmod = {r.hs, col[c.cb-2], col[2*c.cb-2], col[3*c.cb-2],
              r.vs, col[c.cb-1], col[2*c.cb-1], col[3*c.cb-1]};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    k = 0;
    chk("reset_a", obs_a, ref_model(cfg_a, 0, '0));
    chk("reset_b", obs_b, ref_model(cfg_b, 0, '0));
    rst_n = 1'b1;
  endtask

  localparam int NCYC = 256 * 128 + 200;

  initial begin
    logic [5:0] prev_a;
    logic [8:0] prev_b;
    int hs_low, vs_hi;
    longint fall1, fall2, fs1, fs2;
    logic hs_prev;

    cfg_a = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33, lat:0, cb:2, hpol:1'b0, vpol:1'b0};
    cfg_b = '{ha:8, hfp:2, hsw:3, hbp:3, va:4, vfp:1, vsw:2, vbp:1, lat:3, cb:3, hpol:1'b0, vpol:1'b1};

    tbl[0] = '{k:1,   rgb:6'h3F, x:10'd1,   hs:1'b1, de:1'b1, ro:6'h3F};
    tbl[1] = '{k:2,   rgb:6'h15, x:10'd2,   hs:1'b1, de:1'b1, ro:6'h15};
    tbl[2] = '{k:640, rgb:6'h2A, x:10'd640, hs:1'b1, de:1'b1, ro:6'h2A};
    tbl[3] = '{k:641, rgb:6'h3F, x:10'd641, hs:1'b1, de:1'b0, ro:6'h00};
    tbl[4] = '{k:656, rgb:6'h3F, x:10'd656, hs:1'b1, de:1'b0, ro:6'h00};
    tbl[5] = '{k:657, rgb:6'h3F, x:10'd657, hs:1'b0, de:1'b0, ro:6'h00};
    tbl[6] = '{k:752, rgb:6'h3F, x:10'd752, hs:1'b0, de:1'b0, ro:6'h00};
    tbl[7] = '{k:753, rgb:6'h3F, x:10'd753, hs:1'b1, de:1'b0, ro:6'h00};
    tbl[8] = '{k:800, rgb:6'h3F, x:10'd0,   hs:1'b1, de:1'b0, ro:6'h00};
    tbl[9] = '{k:801, rgb:6'h07, x:10'd1,   hs:1'b1, de:1'b1, ro:6'h07};

    rgb_a = '0;
    rgb_b = '0;
    k     = 0;
    @(negedge clk);
    do_reset();

    // Line timing and blanking on the 640x480 instance
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        rgb_a = tbl[i].rgb;
        step();
      end
      chk($sformatf("tbl%0d_x", i),   px_a, tbl[i].x);
      chk($sformatf("tbl%0d_hs", i),  hs_a, tbl[i].hs);
      chk($sformatf("tbl%0d_de", i),  de_a, tbl[i].de);
      chk($sformatf("tbl%0d_rgb", i), ro_a, tbl[i].ro);
    end

    // Mid-line reset while hsync is active: asynchronous return to idle
    rgb_a = 6'h3F;
    while (k < 1500) step();
    chk("pre_rst_hs", hs_a, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hs",  hs_a, 1'b1);
    chk("async_rst_x",   px_a, 10'd0);
    chk("async_rst_y",   py_a, 10'd0);
    chk("async_rst_rgb", ro_a, 6'h00);
    @(posedge clk);
    @(negedge clk);
    k = 0;
    chk("held_rst_a", obs_a, ref_model(cfg_a, 0, '0));

    // Random colour against the reference model, through a full frame_cnt wrap on the small instance
    do_reset();
    hs_low = 0; vs_hi = 0;
    fall1 = -1; fall2 = -1; fs1 = -1; fs2 = -1;
    hs_prev = hs_a;
    for (int i = 0; i < NCYC; i++) begin
      rgb_a  = 6'($urandom);
      rgb_b  = 9'($urandom);
      prev_a = rgb_a;
      prev_b = rgb_b;
      step();
      chk("model_a", obs_a, ref_model(cfg_a, k, {6'b0, prev_a}));
      chk("model_b", obs_b, ref_model(cfg_b, k, {3'b0, prev_b}));
      if (k <= 800 && !hs_a) hs_low++;
      if (hs_prev && !hs_a) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      hs_prev = hs_a;
      if (k <= 128 && vs_b) vs_hi++;
      if (fs_b) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (k == 32767) chk("fc_b_255", fc_b, 8'd255);
      if (k == 32768) chk("fc_b_wrap", fc_b, 8'd0);
    end
    chk("hsync_low_clks",  hs_low, 96);
    chk("hsync_fall_k",    fall1, 657);
    chk("line_period",     fall2 - fall1, 800);
    chk("vsync_b_clks",    vs_hi, 32);
    chk("frame_period_b",  fs2 - fs1, 128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
